// File: rtl/peripheral_uart_fifo.sv
// peripheral_uart_fifo
//   Memory-mapped UART with TX/RX FIFOs, a run-time baud divisor,
//   a configurable character width and sticky error flags.
//
// Ports
//   clk    system clock, all logic on posedge
//   rst    asynchronous active-high reset
//   d_in   16-bit write data from the processor
//   cs     block select
//   addr   4-bit register address
//   rd     read strobe (RXDATA pops one entry per cycle)
//   wr     write strobe
//   d_out  registered read data, holds until the next read
//   tx     serial output, idle high
//   rx     serial input, asynchronous to clk
//
// Registers: 0x0 TXDATA, 0x2 CTRL, 0x4 STATUS, 0x6 RXDATA, 0x8 DIV, 0xA COUNT
module peripheral_uart_fifo #(
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int DIV_DEFAULT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [3:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] d_out,
  output logic        tx,
  input  logic        rx
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  // bus decode
  logic wr_sel, rd_sel, wr_txdata, wr_ctrl, wr_div, rd_rxdata, flush, clr_err;

  assign wr_sel    = cs & wr;
  assign rd_sel    = cs & rd;
  assign wr_txdata = wr_sel && (addr == 4'h0);
  assign wr_ctrl   = wr_sel && (addr == 4'h2);
  assign wr_div    = wr_sel && (addr == 4'h8);
  assign rd_rxdata = rd_sel && (addr == 4'h6);
  assign flush     = wr_ctrl & d_in[3];
  assign clr_err   = wr_ctrl & d_in[2];

  // control and sticky flags
  logic        tx_en, rx_en;
  logic [15:0] div_reg;
  logic        tx_ovf, rx_ovf, frame_err;
  logic        tx_ovf_set, rx_ovf_set, frame_err_set;

  // set beats clear when both land in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_en     <= 1'b1;
      rx_en     <= 1'b1;
      div_reg   <= 16'(DIV_DEFAULT);
      tx_ovf    <= 1'b0;
      rx_ovf    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        tx_en <= d_in[0];
        rx_en <= d_in[1];
      end
      if (wr_div) div_reg <= (d_in < 16'd4) ? 16'd4 : d_in;
      tx_ovf    <= tx_ovf_set    | (tx_ovf    & ~clr_err);
      rx_ovf    <= rx_ovf_set    | (rx_ovf    & ~clr_err);
      frame_err <= frame_err_set | (frame_err & ~clr_err);
    end
  end

  // TX FIFO
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0]        tx_wptr, tx_rptr;
  logic [CW-1:0]        tx_count;
  logic                 tx_full, tx_empty, tx_push, tx_pop;
  logic [DATA_BITS-1:0] tx_head;

  assign tx_full    = (tx_count == FULL_CNT);
  assign tx_empty   = (tx_count == '0);
  assign tx_head    = tx_mem[tx_rptr];
  // a same-cycle pop frees the slot the write needs
  assign tx_push    = wr_txdata && (!tx_full || tx_pop) && !flush;
  assign tx_ovf_set = wr_txdata && tx_full && !tx_pop && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else if (flush) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + AW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + AW'(1);
      tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr] <= d_in[DATA_BITS-1:0];
  end

  // TX FSM
  uart_state_t          tx_state, tx_state_next;
  logic [15:0]          tx_div, tx_baud;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_bit_end, tx_can_start, tx_busy;

  assign tx_bit_end   = (tx_baud == tx_div - 16'd1);
  assign tx_can_start = tx_en && !tx_empty && !flush;
  assign tx_busy      = (tx_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= S_IDLE;
    else     tx_state <= tx_state_next;
  end

  // STOP may chain straight into START so queued frames have no gap
  always_comb begin
    tx_state_next = tx_state;
    tx_pop        = 1'b0;
    case (tx_state)
      S_IDLE:  if (tx_can_start) begin
                 tx_state_next = S_START;
                 tx_pop        = 1'b1;
               end
      S_START: if (tx_bit_end) tx_state_next = S_DATA;
      S_DATA:  if (tx_bit_end && tx_bit == LAST_BIT) tx_state_next = S_STOP;
      S_STOP:  if (tx_bit_end) begin
                 if (tx_can_start) begin
                   tx_state_next = S_START;
                   tx_pop        = 1'b1;
                 end else begin
                   tx_state_next = S_IDLE;
                 end
               end
      default: tx_state_next = S_IDLE;
    endcase
  end

  // tx is registered from the current state, so the line lags the FSM by one clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_div   <= 16'(DIV_DEFAULT);
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
    end else begin
      if (tx_pop) begin
        tx_shift <= tx_head;
        tx_div   <= div_reg;
        tx_baud  <= '0;
        tx_bit   <= '0;
      end else if (tx_state != S_IDLE) begin
        if (tx_bit_end) begin
          tx_baud <= '0;
          if (tx_state == S_DATA) begin
            tx_shift <= tx_shift >> 1;
            tx_bit   <= tx_bit + BW'(1);
          end
        end else begin
          tx_baud <= tx_baud + 16'd1;
        end
      end
      case (tx_state)
        S_START: tx <= 1'b0;
        S_DATA:  tx <= tx_shift[0];
        default: tx <= 1'b1;
      endcase
    end
  end

  // RX synchroniser and falling-edge detect
  logic rx_meta, rx_sync, rx_prev, rx_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  // RX FIFO
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]        rx_wptr, rx_rptr;
  logic [CW-1:0]        rx_count;
  logic                 rx_full, rx_empty, rx_done, rx_push, rx_pop;
  logic [DATA_BITS-1:0] rx_head, rx_shift;

  assign rx_full    = (rx_count == FULL_CNT);
  assign rx_empty   = (rx_count == '0);
  assign rx_head    = rx_mem[rx_rptr];
  assign rx_push    = rx_done && !rx_full && !flush;
  assign rx_ovf_set = rx_done && rx_full && !flush;
  assign rx_pop     = rd_rxdata && !rx_empty && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else if (flush) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + AW'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + AW'(1);
      rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr] <= rx_shift;
  end

  // RX FSM
  uart_state_t   rx_state, rx_state_next;
  logic [15:0]   rx_div, rx_baud;
  logic [BW-1:0] rx_bit;
  logic          rx_start, rx_bit_end, rx_half;

  assign rx_bit_end = (rx_baud == rx_div - 16'd1);
  assign rx_half    = (rx_baud == (rx_div >> 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= S_IDLE;
    else     rx_state <= rx_state_next;
  end

  // start bit is re-checked half a bit in to reject short glitches
  always_comb begin
    rx_state_next = rx_state;
    rx_start      = 1'b0;
    rx_done       = 1'b0;
    frame_err_set = 1'b0;
    case (rx_state)
      S_IDLE:  if (rx_en && rx_fall) begin
                 rx_state_next = S_START;
                 rx_start      = 1'b1;
               end
      S_START: if (rx_half) rx_state_next = rx_sync ? S_IDLE : S_DATA;
      S_DATA:  if (rx_bit_end && rx_bit == LAST_BIT) rx_state_next = S_STOP;
      S_STOP:  if (rx_bit_end) begin
                 rx_state_next = S_IDLE;
                 if (rx_sync) rx_done       = 1'b1;
                 else         frame_err_set = 1'b1;
               end
      default: rx_state_next = S_IDLE;
    endcase
  end

  // data bits shift in at the top so the first (LSB) bit ends at bit 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_div   <= 16'(DIV_DEFAULT);
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else if (rx_start) begin
      rx_div  <= div_reg;
      rx_baud <= '0;
      rx_bit  <= '0;
    end else begin
      case (rx_state)
        S_START: rx_baud <= rx_half ? 16'd0 : rx_baud + 16'd1;
        S_DATA:  if (rx_bit_end) begin
                   rx_baud  <= '0;
                   rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                   rx_bit   <= rx_bit + BW'(1);
                 end else begin
                   rx_baud <= rx_baud + 16'd1;
                 end
        S_STOP:  rx_baud <= rx_bit_end ? 16'd0 : rx_baud + 16'd1;
        default: rx_baud <= '0;
      endcase
    end
  end

  // read mux and registered read data
  logic [6:0]  status;
  logic [7:0]  tx_cnt8, rx_cnt8;
  logic [15:0] rd_data;

  assign status  = {frame_err, rx_ovf, tx_ovf, ~rx_empty, tx_busy, tx_empty, tx_full};
  assign tx_cnt8 = 8'(tx_count);
  assign rx_cnt8 = 8'(rx_count);

  always_comb begin
    rd_data = '0;
    case (addr)
      4'h2:    rd_data = {14'd0, rx_en, tx_en};
      4'h4:    rd_data = {9'd0, status};
      4'h6:    if (!rx_empty) rd_data = 16'(rx_head);
      4'h8:    rd_data = div_reg;
      4'hA:    rd_data = {rx_cnt8, tx_cnt8};
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         d_out <= '0;
    else if (rd_sel) d_out <= rd_data;
  end

endmodule
